// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Brief    : Shared widths and saturation bounds for the vector MAC PE.
// Revision : 1.0  initial release
// ============================================================================
package pe_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Full-precision width of a LANES-term signed dot product.
    function automatic int dot_width(input int bitwidth, input int lanes);
        return 2 * bitwidth + clog2(lanes);
    endfunction

    // Bounds are returned sign-extended to 64 bits; callers keep the low bits.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_dot_lanes.sv
`default_nettype none
// ============================================================================
// Module   : pe_dot_lanes
// Brief    : Combinational LANES-wide signed multiply and reduction.
// Revision : 1.0  initial release
// ============================================================================
module pe_dot_lanes
    import pe_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int LANES    = 4,
    parameter int DOT_W    = 18
) (
    input  logic [LANES*BITWIDTH-1:0] i_a,
    input  logic [LANES*BITWIDTH-1:0] i_b,
    output logic [DOT_W-1:0]          o_dot
);

    localparam int c_PW = 2 * BITWIDTH;

    logic [DOT_W-1:0] w_term [LANES];
    logic [DOT_W-1:0] w_sum;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic signed [c_PW-1:0] w_a_ext;
            logic signed [c_PW-1:0] w_b_ext;
            logic signed [c_PW-1:0] w_prod;

            // Operands are widened first so the product is exact in c_PW bits.
            assign w_a_ext = {{BITWIDTH{i_a[g*BITWIDTH+BITWIDTH-1]}}, i_a[g*BITWIDTH +: BITWIDTH]};
            assign w_b_ext = {{BITWIDTH{i_b[g*BITWIDTH+BITWIDTH-1]}}, i_b[g*BITWIDTH +: BITWIDTH]};
            assign w_prod  = w_a_ext * w_b_ext;

            if (DOT_W > c_PW) begin : g_ext
                assign w_term[g] = {{(DOT_W-c_PW){w_prod[c_PW-1]}}, w_prod};
            end else begin : g_noext
                assign w_term[g] = w_prod;
            end
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + w_term[i];
        end
    end

    assign o_dot = w_sum;

endmodule : pe_dot_lanes
`default_nettype wire

// File: rtl/pe_vec_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_vec_mac
// Brief    : Systolic PE: forwards operands, dot product stage, tile accumulator.
// Revision : 1.0  initial release
// ============================================================================
module pe_vec_mac
    import pe_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 24,
    parameter int SATURATE  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [LANES*BITWIDTH-1:0] in_a,
    input  logic [LANES*BITWIDTH-1:0] in_b,
    output logic [LANES*BITWIDTH-1:0] out_a,
    output logic [LANES*BITWIDTH-1:0] out_b,
    output logic                      out_valid,
    output logic                      out_first,
    output logic                      out_last,
    output logic [ACC_WIDTH-1:0]      result,
    output logic                      result_valid,
    output logic                      overflow
);

    localparam int c_DOT_W = dot_width(BITWIDTH, LANES);
    localparam logic [63:0] c_SAT_MAX64 = sat_max(ACC_WIDTH);
    localparam logic [63:0] c_SAT_MIN64 = sat_min(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] c_SAT_MAX = c_SAT_MAX64[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] c_SAT_MIN = c_SAT_MIN64[ACC_WIDTH-1:0];

    generate
        if (ACC_WIDTH < c_DOT_W) begin : g_bad_acc_width
            $error("pe_vec_mac: ACC_WIDTH smaller than the dot-product width");
        end
    endgenerate

    logic [LANES*BITWIDTH-1:0] r_out_a;
    logic [LANES*BITWIDTH-1:0] r_out_b;
    logic                      r_out_valid;
    logic                      r_out_first;
    logic                      r_out_last;

    logic [c_DOT_W-1:0]        r_s1_dot;
    logic                      r_s1_valid;
    logic                      r_s1_first;
    logic                      r_s1_last;

    logic [ACC_WIDTH-1:0]      r_acc;
    logic                      r_ovf;
    logic [ACC_WIDTH-1:0]      r_result;
    logic                      r_result_valid;
    logic                      r_overflow;

    logic [c_DOT_W-1:0]        w_dot;
    logic [ACC_WIDTH-1:0]      w_base;
    logic [ACC_WIDTH:0]        w_dot_ext;
    logic [ACC_WIDTH:0]        w_sum;
    logic                      w_oor;
    logic [ACC_WIDTH-1:0]      w_acc_next;
    logic                      w_ovf_next;
    logic                      w_publish;

    pe_dot_lanes #(
        .BITWIDTH (BITWIDTH),
        .LANES    (LANES),
        .DOT_W    (c_DOT_W)
    ) u_dot (
        .i_a   (in_a),
        .i_b   (in_b),
        .o_dot (w_dot)
    );

    // Sum is one bit wider than the accumulator so the top two bits expose overflow.
    assign w_base    = r_s1_first ? '0 : r_acc;
    assign w_dot_ext = {{(ACC_WIDTH+1-c_DOT_W){r_s1_dot[c_DOT_W-1]}}, r_s1_dot};
    assign w_sum     = {w_base[ACC_WIDTH-1], w_base} + w_dot_ext;
    assign w_oor     = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (w_oor && (SATURATE != 0)) begin
            w_acc_next = w_sum[ACC_WIDTH] ? c_SAT_MIN : c_SAT_MAX;
        end
    end

    assign w_ovf_next = (r_s1_first ? 1'b0 : r_ovf) | w_oor;
    assign w_publish  = r_s1_valid & r_s1_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_a        <= '0;
            r_out_b        <= '0;
            r_out_valid    <= 1'b0;
            r_out_first    <= 1'b0;
            r_out_last     <= 1'b0;
            r_s1_dot       <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_first     <= 1'b0;
            r_s1_last      <= 1'b0;
            r_acc          <= '0;
            r_ovf          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (en) begin
            r_out_a     <= in_a;
            r_out_b     <= in_b;
            r_out_valid <= in_valid;
            r_out_first <= in_first;
            r_out_last  <= in_last;

            r_s1_valid  <= in_valid;
            if (in_valid) begin
                r_s1_dot   <= w_dot;
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
            end

            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
            end

            r_result_valid <= w_publish;
            if (w_publish) begin
                r_result   <= w_acc_next;
                r_overflow <= w_ovf_next;
            end
        end
    end

    assign out_a        = r_out_a;
    assign out_b        = r_out_b;
    assign out_valid    = r_out_valid;
    assign out_first    = r_out_first;
    assign out_last     = r_out_last;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;

endmodule : pe_vec_mac
`default_nettype wire
